cla_serial_adder: RTL and testbench

- Multi-cycle carry-lookahead adder built on the partial-full-adder generate/propagate contract (Gi = A&B, Pi = A|B, S = A^B^Cin).
- Consumes operands GROUP bits per cycle. Within a group, carries come from a lookahead over (Gi, Pi). Between groups, the carry is held in a register.
- Sits behind a valid/ready front end so that datapath stages can issue additions without instantiating a full-width CLA tree.

---
 rtl/cla_pkg.sv | 18 +
 rtl/cla_group.sv | 52 +++++
 rtl/cla_serial_adder.sv | 124 ++++++++++++
 tb/tb_cla_serial_adder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and sizing helpers for the serial carry-lookahead adder.
// Purely declarative: no logic, no latency, no flow control.
package cla_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int ngroups(input int width, input int group);
        return width / group;
    endfunction

    // A single-group build still needs a 1-bit index register.
    function automatic int idx_width(input int ng);
        return (ng > 1) ? $clog2(ng) : 1;
    endfunction

    localparam int CLA_DEF_IDX_W = idx_width(ngroups(16, 4));

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit lookahead slice: flat carries from (g, p), sum, group G/P.
// Combinational, zero latency; no flow control.
// Carry into the MSB is exported so the top can form signed overflow.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             co,
    output logic             c_msb,
    output logic             gg,
    output logic             pg
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;

    // Carry into bit n as a two-level sum of products: every generate term
    // ANDed with the propagates above it, plus the all-propagate path from c0.
    function automatic logic carry_at(input int n, input logic [GROUP-1:0] gv,
                                      input logic [GROUP-1:0] pv, input logic c0);
        logic acc;
        logic term;
        acc = c0;
        for (int j = 0; j < n; j++) acc = acc & pv[j];
        for (int j = 0; j < n; j++) begin
            term = gv[j];
            for (int k = j + 1; k < n; k++) term = term & pv[k];
            acc = acc | term;
        end
        return acc;
    endfunction

    assign g = a & b;
    assign p = a | b;

    always_comb begin
        c    = '0;
        c[0] = ci;
        for (int i = 1; i <= GROUP; i++) c[i] = carry_at(i, g, p, ci);
    end

    assign s     = a ^ b ^ c[GROUP-1:0];
    assign co    = c[GROUP];
    assign c_msb = c[GROUP-1];
    assign gg    = carry_at(GROUP, g, p, 1'b0);
    assign pg    = &p;

endmodule

// File: rtl/cla_serial_adder.sv
// Multi-cycle adder resolving GROUP bits per cycle; CLA_SUB_EN adds a sub port (a-b).
// Latency: out_valid rises NGROUPS edges after acceptance; in_ready low during RUN/DONE.
// Backpressure: result held stable in DONE until out_ready; one op in flight at a time.
module cla_serial_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = ngroups(WIDTH, GROUP);
    localparam int IW = idx_width(NG);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic [GROUP-1:0] a_sl, b_sl, s_sl;
    logic             g_co, g_cmsb, g_gg, g_pg;

    assign a_sl = a_q[int'(idx_q)*GROUP +: GROUP];
    assign b_sl = b_q[int'(idx_q)*GROUP +: GROUP];

    cla_group #(.GROUP(GROUP)) u_group (
        .a     (a_sl),
        .b     (b_sl),
        .ci    (carry_q),
        .s     (s_sl),
        .co    (g_co),
        .c_msb (g_cmsb),
        .gg    (g_gg),
        .pg    (g_pg)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
`ifdef CLA_SUB_EN
                    // Subtraction as a + ~b + 1; the operand is inverted once at capture.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
`else
                    b_d     = b;
                    carry_d = cin;
`endif
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(idx_q)*GROUP +: GROUP] = s_sl;
                carry_d = g_gg | (g_pg & carry_q);
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(NG - 1)) begin
                    cout_d  = g_co;
                    ovf_d   = g_co ^ g_cmsb;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Randomized and directed checks of cla_serial_adder against a plain-arithmetic model.
module tb_cla_serial_adder;

    localparam int W  = 16;
    localparam int G  = 4;
    localparam int NG = W / G;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cla_serial_adder #(.WIDTH(W), .GROUP(G)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Returns {ovf, cout, sum} computed with whole-word arithmetic.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci, input logic s);
        logic [W-1:0] yy;
        logic         c0;
        logic [W:0]   r;
        logic         v;
        yy = s ? ~y : y;
        c0 = s ? 1'b1 : ci;
        r  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c0};
        v  = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
        return {v, r};
    endfunction

    // Drives one transaction and reports what the DUT produced; lat counts edges after acceptance.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          input logic s, output logic [W-1:0] rs, output logic rc,
                          output logic rv, output int lat);
        @(negedge clk);
        a = x; b = y; cin = ci; sub_i = s; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub_i = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        rs = sum; rc = cout; rv = ovf;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (sum !== '0) $display("FAIL reset_sum: got %h want 0000", sum); else n_pass++;
        n_total++; if (cout !== 1'b0) $display("FAIL reset_cout: got %b want 0", cout); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [W-1:0] ta [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h00F0, 16'h0FFF};
        logic [W-1:0] tb [6] = '{16'h4321, 16'h0001, 16'h0001, 16'h8000, 16'h000F, 16'h0000};
        logic         tc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] es [6] = '{16'h5555, 16'h0000, 16'h8000, 16'h0000, 16'h0100, 16'h1000};
        logic         ec [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic         ev [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] rs;
        logic         rc, rv;
        int           lat;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], tc[i], 1'b0, rs, rc, rv, lat);
            n_total++; if (rs !== es[i]) $display("FAIL dir%0d_sum: got %h want %h", i, rs, es[i]); else n_pass++;
            n_total++; if (rc !== ec[i]) $display("FAIL dir%0d_cout: got %b want %b", i, rc, ec[i]); else n_pass++;
            n_total++; if (rv !== ev[i]) $display("FAIL dir%0d_ovf: got %b want %b", i, rv, ev[i]); else n_pass++;
            n_total++; if (lat !== NG) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, NG); else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        logic [W+1:0] exp;
        int           waited;
        exp = ref_add(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        a = 16'hA5A5; b = 16'h5A5A; cin = 1'b1; sub_i = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        waited = 0;
        while (!out_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        n_total++; if (waited !== NG) $display("FAIL bp_latency: got %0d want %0d", waited, NG); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            @(negedge clk);
            n_total++; if (out_valid !== 1'b1) $display("FAIL bp%0d_out_valid: got %b want 1", i, out_valid); else n_pass++;
            n_total++; if (in_ready !== 1'b0) $display("FAIL bp%0d_in_ready: got %b want 0", i, in_ready); else n_pass++;
            n_total++; if (sum !== exp[W-1:0]) $display("FAIL bp%0d_sum: got %h want %h", i, sum, exp[W-1:0]); else n_pass++;
            n_total++; if (cout !== exp[W]) $display("FAIL bp%0d_cout: got %b want %b", i, cout, exp[W]); else n_pass++;
            n_total++; if (ovf !== exp[W+1]) $display("FAIL bp%0d_ovf: got %b want %b", i, ovf, exp[W+1]); else n_pass++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL bp_release_out_valid: got %b want 0", out_valid); else n_pass++;
        @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_idle_hold: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        logic [W-1:0] rs;
        logic         rc, rv;
        int           lat;
        @(negedge clk);
        a = 16'h1111; b = 16'h1111; cin = 1'b0; sub_i = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        n_total++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (sum !== '0) $display("FAIL midrst_sum: got %h want 0000", sum); else n_pass++;
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, rs, rc, rv, lat);
        n_total++; if (rs !== 16'h0002) $display("FAIL midrst_after_sum: got %h want 0002", rs); else n_pass++;
        n_total++; if (rc !== 1'b0) $display("FAIL midrst_after_cout: got %b want 0", rc); else n_pass++;
        n_total++; if (lat !== NG) $display("FAIL midrst_after_latency: got %0d want %0d", lat, NG); else n_pass++;
    endtask

    task automatic test_random;
        logic [W-1:0] x, y, rs;
        logic         ci, s, rc, rv;
        logic [W+1:0] exp;
        int           lat;
        for (int i = 0; i < 40; i++) begin
            x  = W'($urandom);
            y  = W'($urandom);
            ci = 1'($urandom);
            s  = 1'b0;
`ifdef CLA_SUB_EN
            s  = 1'($urandom);
`endif
            // Bias some operands toward long propagate chains.
            if (i % 4 == 0) y = ~x;
            exp = ref_add(x, y, ci, s);
            run_op(x, y, ci, s, rs, rc, rv, lat);
            n_total++; if (rs !== exp[W-1:0]) $display("FAIL rnd%0d_sum: %h+%h c%b s%b got %h want %h", i, x, y, ci, s, rs, exp[W-1:0]); else n_pass++;
            n_total++; if (rc !== exp[W]) $display("FAIL rnd%0d_cout: got %b want %b", i, rc, exp[W]); else n_pass++;
            n_total++; if (rv !== exp[W+1]) $display("FAIL rnd%0d_ovf: got %b want %b", i, rv, exp[W+1]); else n_pass++;
            n_total++; if (lat !== NG) $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, NG); else n_pass++;
        end
    endtask

`ifdef CLA_SUB_EN
    task automatic test_sub;
        logic [W-1:0] rs;
        logic         rc, rv;
        int           lat;
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, rs, rc, rv, lat);
        n_total++; if (rs !== 16'hFFFE) $display("FAIL sub0_sum: got %h want fffe", rs); else n_pass++;
        n_total++; if (rc !== 1'b0) $display("FAIL sub0_cout: got %b want 0", rc); else n_pass++;
        n_total++; if (rv !== 1'b0) $display("FAIL sub0_ovf: got %b want 0", rv); else n_pass++;
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, rs, rc, rv, lat);
        n_total++; if (rs !== 16'h0002) $display("FAIL sub1_sum: got %h want 0002", rs); else n_pass++;
        n_total++; if (rc !== 1'b1) $display("FAIL sub1_cout: got %b want 1", rc); else n_pass++;
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub_i     = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random();
`ifdef CLA_SUB_EN
        test_sub();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
